// File: rtl/rgb_block_serializer_if.sv
// Bus bundle between the colour block source, the block serializer and the pixel sink.
// The source/sink side uses master; the serializer uses slave.
interface rgb_block_serializer_if #(
    parameter int PIX_W = 8,
    parameter int CNT_W = 16
);
    logic                         valid_in;
    logic [7:0][7:0][PIX_W-1:0]   r;
    logic [7:0][7:0][PIX_W-1:0]   g;
    logic [7:0][7:0][PIX_W-1:0]   b;
    logic                         space_avail;
    logic                         overflow;
    logic                         pix_valid;
    logic                         pix_ready;
    logic [PIX_W-1:0]             pix_r;
    logic [PIX_W-1:0]             pix_g;
    logic [PIX_W-1:0]             pix_b;
    logic [2:0]                   pix_row;
    logic [2:0]                   pix_col;
    logic                         pix_last;
    logic [CNT_W-1:0]             blk_cnt;

    modport master (
        output valid_in, r, g, b, pix_ready,
        input  space_avail, overflow, pix_valid, pix_r, pix_g, pix_b,
               pix_row, pix_col, pix_last, blk_cnt
    );

    modport slave (
        input  valid_in, r, g, b, pix_ready,
        output space_avail, overflow, pix_valid, pix_r, pix_g, pix_b,
               pix_row, pix_col, pix_last, blk_cnt
    );
endinterface

// File: rtl/rgb_block_serializer.sv
// Ping-pong buffer that captures whole 8x8 RGB blocks in one cycle and
// streams them out one raster-ordered pixel per valid/ready handshake.
module rgb_block_serializer #(
    parameter int PIX_W = 8,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    rgb_block_serializer_if.slave  bus
);
    // A block is stored flat: element row*8+col, so the pixel index addresses it directly.
    logic [63:0][PIX_W-1:0] slot_r_reg [2];
    logic [63:0][PIX_W-1:0] slot_g_reg [2];
    logic [63:0][PIX_W-1:0] slot_b_reg [2];

    logic             wp_reg;
    logic             rp_reg;
    logic [1:0]       count_reg;
    logic [5:0]       idx_reg;
    logic             overflow_reg;
    logic [CNT_W-1:0] blk_cnt_reg;

    logic pix_valid;
    logic transfer;
    logic drain_done;
    logic capture;

    assign pix_valid  = (count_reg != 2'd0);
    assign transfer   = pix_valid && bus.pix_ready;
    assign drain_done = transfer && (idx_reg == 6'd63);
    // The last pixel of the slot being freed is read before this edge, so a full
    // buffer can still take a block on the drain-complete cycle.
    assign capture    = bus.valid_in && ((count_reg < 2'd2) || drain_done);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    slot_r_reg[gi] <= '0;
                    slot_g_reg[gi] <= '0;
                    slot_b_reg[gi] <= '0;
                end else if (capture && (wp_reg == 1'(gi))) begin
                    slot_r_reg[gi] <= bus.r;
                    slot_g_reg[gi] <= bus.g;
                    slot_b_reg[gi] <= bus.b;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_reg       <= 1'b0;
            rp_reg       <= 1'b0;
            count_reg    <= 2'd0;
            idx_reg      <= 6'd0;
            overflow_reg <= 1'b0;
            blk_cnt_reg  <= '0;
        end else begin
            if (capture) begin
                wp_reg <= ~wp_reg;
            end
            if (bus.valid_in && !capture) begin
                overflow_reg <= 1'b1;
            end
            if (transfer) begin
                idx_reg <= idx_reg + 6'd1;
            end
            if (drain_done) begin
                rp_reg      <= ~rp_reg;
                blk_cnt_reg <= blk_cnt_reg + 1'b1;
            end
            case ({capture, drain_done})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign bus.pix_valid   = pix_valid;
    assign bus.space_avail = (count_reg < 2'd2);
    assign bus.overflow    = overflow_reg;
    assign bus.blk_cnt     = blk_cnt_reg;
    assign bus.pix_r       = slot_r_reg[rp_reg][idx_reg];
    assign bus.pix_g       = slot_g_reg[rp_reg][idx_reg];
    assign bus.pix_b       = slot_b_reg[rp_reg][idx_reg];
    assign bus.pix_row     = idx_reg[5:3];
    assign bus.pix_col     = idx_reg[2:0];
    assign bus.pix_last    = pix_valid && (idx_reg == 6'd63);
endmodule

// File: tb/tb_rgb_block_serializer.sv
// Randomised bench for rgb_block_serializer: a pixel-queue model is compared with
// the DUT every cycle, with literal spot checks pinning the model at key points.
module tb_rgb_block_serializer;
    localparam int PIX_W = 8;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rgb_block_serializer_if #(.PIX_W(PIX_W), .CNT_W(CNT_W)) bus ();

    rgb_block_serializer #(.PIX_W(PIX_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model: flat queue of pending pixels {r,g,b}; head is the pixel on display.
    logic [3*PIX_W-1:0] pq[$];
    logic               m_ovf = 1'b0;
    logic [CNT_W-1:0]   m_bc  = '0;

    function automatic int m_blocks();
        return (pq.size() + 63) / 64;
    endfunction

    function automatic int m_idx();
        if (pq.size() == 0) return 0;
        return (64 - (pq.size() % 64)) % 64;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pq.delete();
            m_ovf = 1'b0;
            m_bc  = '0;
        end else begin
            automatic int  nb   = m_blocks();
            automatic bit  xfer = (pq.size() != 0) && bus.pix_ready;
            automatic bit  done = xfer && (m_idx() == 63);
            if (xfer) begin
                void'(pq.pop_front());
                if (done) m_bc = m_bc + 1'b1;
            end
            if (bus.valid_in) begin
                if (nb < 2 || done) begin
                    for (int i = 0; i < 64; i++)
                        pq.push_back({bus.r[i/8][i%8], bus.g[i/8][i%8], bus.b[i/8][i%8]});
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        automatic bit exp_v = (pq.size() != 0);
        automatic int ix    = m_idx();
        chk("pix_valid", 32'(bus.pix_valid), 32'(exp_v));
        chk("space_avail", 32'(bus.space_avail), 32'(m_blocks() < 2));
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));
        chk("blk_cnt", 32'(bus.blk_cnt), 32'(m_bc));
        chk("pix_last", 32'(bus.pix_last), 32'(exp_v && ix == 63));
        if (exp_v) begin
            chk("pix_rgb", 32'({bus.pix_r, bus.pix_g, bus.pix_b}), 32'(pq[0]));
            chk("pix_pos", 32'({bus.pix_row, bus.pix_col}), 32'(ix));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: r=8i+j, g=255-(8i+j), b=0x5A; otherwise random samples
    task automatic set_block(input int mode);
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                if (mode == 0) begin
                    bus.r[i][j] = PIX_W'(8 * i + j);
                    bus.g[i][j] = PIX_W'(255 - (8 * i + j));
                    bus.b[i][j] = PIX_W'(8'h5A);
                end else begin
                    bus.r[i][j] = PIX_W'($urandom);
                    bus.g[i][j] = PIX_W'($urandom);
                    bus.b[i][j] = PIX_W'($urandom);
                end
            end
        end
    endtask

    task automatic strobe(input int mode);
        set_block(mode);
        bus.valid_in = 1'b1;
        tick();
        bus.valid_in = 1'b0;
    endtask

    task automatic wait_empty(input int bound);
        int n = 0;
        while (pq.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        chk("drain_within_bound", 32'(pq.size() != 0), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        int sent;
        int cyc;
        bus.valid_in  = 1'b0;
        bus.pix_ready = 1'b0;
        set_block(0);
        do_reset();
        chk("reset_pix_valid", 32'(bus.pix_valid), 32'd0);
        chk("reset_space_avail", 32'(bus.space_avail), 32'd1);
        chk("reset_pix_r", 32'(bus.pix_r), 32'd0);
        chk("reset_pos", 32'({bus.pix_row, bus.pix_col}), 32'd0);
        chk("reset_blk_cnt", 32'(bus.blk_cnt), 32'd0);

        // Single patterned block, ready held high
        bus.pix_ready = 1'b1;
        strobe(0);
        chk("first_pix_valid", 32'(bus.pix_valid), 32'd1);
        chk("first_pix_rgb", 32'({bus.pix_r, bus.pix_g, bus.pix_b}), 32'h00FF5A);
        repeat (63) tick();
        chk("last_pix_r", 32'(bus.pix_r), 32'd63);
        chk("last_pix_last", 32'(bus.pix_last), 32'd1);
        tick();
        chk("single_blk_cnt", 32'(bus.blk_cnt), 32'd1);
        chk("single_idle", 32'(bus.pix_valid), 32'd0);

        // Three blocks 64 cycles apart: contiguous stream
        for (int k = 0; k < 3; k++) begin
            strobe(1);
            repeat (63) tick();
        end
        wait_empty(200);
        chk("three_blk_cnt", 32'(bus.blk_cnt), 32'd4);
        chk("three_overflow", 32'(bus.overflow), 32'd0);

        // Stalled: A, B fill, C dropped
        bus.pix_ready = 1'b0;
        strobe(1);
        chk("stall_space_a", 32'(bus.space_avail), 32'd1);
        strobe(1);
        chk("stall_space_b", 32'(bus.space_avail), 32'd0);
        strobe(1);
        chk("stall_overflow", 32'(bus.overflow), 32'd1);
        bus.pix_ready = 1'b1;
        wait_empty(300);
        chk("stall_blk_cnt", 32'(bus.blk_cnt), 32'd6);

        // Third strobe coincides with drain-complete of A
        do_reset();
        bus.pix_ready = 1'b0;
        strobe(1);
        strobe(1);
        bus.pix_ready = 1'b1;
        repeat (63) tick();
        chk("coincide_last", 32'(bus.pix_last), 32'd1);
        strobe(1);
        chk("coincide_overflow", 32'(bus.overflow), 32'd0);
        chk("coincide_space", 32'(bus.space_avail), 32'd0);
        chk("coincide_blk_cnt", 32'(bus.blk_cnt), 32'd1);
        wait_empty(300);
        chk("coincide_final_cnt", 32'(bus.blk_cnt), 32'd3);

        // Random backpressure over four blocks
        sent = 0;
        cyc  = 0;
        while ((sent < 4 || pq.size() != 0) && cyc < 3000) begin
            bus.pix_ready = 1'($urandom_range(0, 1));
            if (sent < 4 && m_blocks() < 2 && $urandom_range(0, 3) == 0) begin
                set_block(1);
                bus.valid_in = 1'b1;
                sent++;
            end
            tick();
            bus.valid_in = 1'b0;
            cyc++;
        end
        chk("random_blk_cnt", 32'(bus.blk_cnt), 32'd7);
        chk("random_overflow", 32'(bus.overflow), 32'd0);

        // Reset during pixel 30 of block 1 with block 2 buffered
        bus.pix_ready = 1'b1;
        strobe(1);
        strobe(1);
        repeat (29) tick();
        chk("pre_rst_pos", 32'({bus.pix_row, bus.pix_col}), 32'd30);
        #2 rst = 1'b1;
        #1;
        chk("rst_pix_valid", 32'(bus.pix_valid), 32'd0);
        chk("rst_pix_rgb", 32'({bus.pix_r, bus.pix_g, bus.pix_b}), 32'd0);
        chk("rst_space", 32'(bus.space_avail), 32'd1);
        chk("rst_blk_cnt", 32'(bus.blk_cnt), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_idle", 32'(bus.pix_valid), 32'd0);
        strobe(0);
        chk("restart_rgb", 32'({bus.pix_r, bus.pix_g, bus.pix_b}), 32'h00FF5A);
        chk("restart_pos", 32'({bus.pix_row, bus.pix_col}), 32'd0);
        wait_empty(200);
        chk("restart_blk_cnt", 32'(bus.blk_cnt), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/rgb_block_serializer.md
# rgb_block_serializer

Downstream stage of `top`: captures each 8×8 RGB block presented on `top`'s `r`/`g`/`b` outputs when `valid_out_Color` pulses, and converts it into a raster-ordered stream of one pixel per handshake. Two block slots (ping-pong) absorb the burstiness of `top`, which cannot be stalled, so a single downstream stall does not lose data. Feeds the frame writer / display path.

## Interface
- `PIX_W`, 8, width of each colour component.
- `CNT_W`, 16, width of the completed-block counter.

- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `valid_in`  in  1  block strobe, driven by `top.valid_out_Color`; one cycle per block.
- `r`, `g`, `b`  in  [PIX_W-1:0] [7:0][7:0]  unsigned block samples, indexed [row][col]; sampled only when `valid_in`=1.
- `space_avail`  out  1  at least one slot is free (count<2).
- `overflow`  out  1  sticky: a block was dropped.
- `pix_valid`  out  1  pixel on `pix_*` is valid.
- `pix_ready`  in  1  downstream accepts pixel.
- `pix_r`, `pix_g`, `pix_b`  out  PIX_W  current pixel components.
- `pix_row`, `pix_col`  out  3  position of current pixel within its block.
- `pix_last`  out  1  current pixel is [7][7] of its block.
- `blk_cnt`  out  CNT_W  number of blocks fully drained.

## Operation
- State: two 64-pixel RGB slots, write pointer `wp` (1 bit), read pointer `rp` (1 bit), `count` (0..2), pixel index `idx` (6 bit; row=`idx[5:3]`, col=`idx[2:0]`), `overflow`, `blk_cnt`.
- Transfer = `pix_valid && pix_ready`. Drain-complete = transfer with `idx`==63.
- Capture: `valid_in` && (`count`<2 || drain-complete) → all 192 samples written to slot `wp`, `wp` toggles.
- Drop: `valid_in` && `count`==2 && !drain-complete → block discarded, `overflow`←1 (cleared only by `rst`); no other state changes from the strobe.
- Drain: on transfer `idx`++; on drain-complete `idx`←0, `rp` toggles, `blk_cnt`++ (wraps 2^CNT_W−1→0).
- `count` next = `count` + capture − drain-complete (capture and drain-complete in same cycle: unchanged).
- `pix_valid` = (`count`≠0). `pix_*` = slot `rp` at (`idx[5:3]`,`idx[2:0]`); `pix_last` = (`idx`==63) && `pix_valid`.
- Output order within block: row 0 col 0..7, row 1 col 0..7, …, row 7 col 7. Blocks leave in capture order.
- `pix_*` data and `pix_valid` hold stable while `pix_valid`=1 and `pix_ready`=0.
- `space_avail` = (`count`<2), decoded from registered state.

## Timing
- Reset (async assert, sync release on next edge): `count`=0, `wp`=`rp`=0, `idx`=0, `overflow`=0, `blk_cnt`=0; thus `pix_valid`=0, `pix_last`=0, `space_avail`=1, `pix_r/g/b`=0, `pix_row/col`=0. Slot contents are zeroed.
- Latency: `valid_in` at edge N into empty buffer → `pix_valid`=1 with pixel [0][0] in the cycle after edge N.
- Throughput: 1 pixel/cycle with `pix_ready` held high; 64 cycles per block; back-to-back blocks have no bubble.
- Write into slot `rp` at the drain-complete edge is legal: the final pixel is read before that edge.
- `rst` mid-block: any partially drained or buffered block is discarded, with no further pixels emitted.
- `blk_cnt` updates on the edge of the drain-complete transfer.

## Test plan
- Single block r[i][j]=8i+j, g=255−(8i+j), b=0x5A; `pix_ready`=1 → 64 consecutive pixels, pix_r 0..63 in order, `pix_last` only on pix_r=63, `blk_cnt` 0→1, `pix_valid` low afterwards.
- Three blocks strobed 64 cycles apart, `pix_ready`=1 → 192 contiguous valid pixels, no gaps, `overflow`=0, `blk_cnt`=3.
- `pix_ready`=0, strobe blocks A, B, C → `space_avail` falls after B, C dropped, `overflow`=1; on release, A then B are emitted and `blk_cnt`=2.
- Buffer full, third strobe in the same cycle as the drain-complete of block A → third block accepted, `overflow` stays 0, `count` stays 2.
- Random `pix_ready` toggling over 4 blocks → every pixel is held stable while stalled, sequence matches a reference model, `blk_cnt`=4.
- `rst` asserted at pixel 30 of block 1 with block 2 buffered → all outputs return to reset values immediately, and the next strobe restarts at [0][0] with `blk_cnt`=0.
